// File: rtl/ram_bist_pkg.sv
// Shared constants for the RAM BIST controller: FSM encoding and default LFSR settings.
package ram_bist_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/ram_bist_lfsr.sv
// Galois LFSR pattern source; load takes priority over step.
module ram_bist_lfsr #(
  parameter int              W    = 8,
  parameter logic [W-1:0]    SEED = W'(8'hA5),
  parameter logic [W-1:0]    TAPS = W'(8'hB8)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED;
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= SEED;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: writes an LFSR pattern to SIZE words, reads it back and counts mismatches.
// Handshake: none; start is a level sampled only in IDLE/DONE, the RAM bus is fire-and-forget.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int                    ADDRWIDTH    = 4,
  parameter int                    DATAWIDTH    = 8,
  parameter int                    SIZE         = 16,
  parameter logic [DATAWIDTH-1:0]  SEED         = DATAWIDTH'(DEFAULT_SEED),
  parameter logic [DATAWIDTH-1:0]  TAPS         = DATAWIDTH'(DEFAULT_TAPS),
  parameter int                    READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [DATAWIDTH-1:0] data,
  output logic                 cs,
  output logic                 we,
  input  logic [DATAWIDTH-1:0] dataOut,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDRWIDTH:0]   err_cnt,
  output logic [ADDRWIDTH-1:0] fail_addr,
  output logic [2:0]           state_dbg
);

  localparam int DRW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(SIZE - 1);
  localparam logic [DRW-1:0]       LAST_DRAIN = DRW'(READ_LATENCY - 1);

  logic [2:0]           state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 cs_q, cs_d, we_q, we_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADDRWIDTH:0]   err_q, err_d;
  logic [ADDRWIDTH-1:0] fail_q, fail_d;
  logic [DRW-1:0]       drain_q, drain_d;

  logic [READ_LATENCY-1:0]                pv_q, pv_d;
  logic [READ_LATENCY-1:0][DATAWIDTH-1:0] pe_q, pe_d;
  logic [READ_LATENCY-1:0][ADDRWIDTH-1:0] pa_q, pa_d;

  logic                 lfsr_load, lfsr_step, push, last_addr, mismatch;
  logic [DATAWIDTH-1:0] lfsr_val;

  ram_bist_lfsr #(.W(DATAWIDTH), .SEED(SEED), .TAPS(TAPS)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  assign last_addr = (addr_q == LAST_ADDR);
  assign mismatch  = pv_q[READ_LATENCY-1] && (dataOut != pe_q[READ_LATENCY-1]);

  // Expected word and address travel alongside the RAM read latency.
  always_comb begin
    pv_d = '0;
    pe_d = '0;
    pa_d = '0;
    pv_d[0] = push;
    pe_d[0] = lfsr_val;
    pa_d[0] = addr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
  end

  // During WRITE the LFSR runs one word ahead of the registered data bus;
  // during READ it holds the word currently being read.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cs_d      = cs_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fail_d    = fail_q;
    drain_d   = drain_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    push      = 1'b0;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + (ADDRWIDTH+1)'(1);
      if (err_q == '0) fail_d = pa_q[READ_LATENCY-1];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WRITE;
          cs_d      = 1'b1;
          we_d      = 1'b1;
          addr_d    = '0;
          data_d    = lfsr_val;
          lfsr_step = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          fail_d    = '0;
        end
      end
      ST_WRITE: begin
        if (last_addr) begin
          state_d   = ST_READ;
          we_d      = 1'b0;
          addr_d    = '0;
          data_d    = '0;
          lfsr_load = 1'b1;
        end else begin
          addr_d    = addr_q + ADDRWIDTH'(1);
          data_d    = lfsr_val;
          lfsr_step = 1'b1;
        end
      end
      ST_READ: begin
        push = 1'b1;
        if (last_addr) begin
          state_d   = ST_DRAIN;
          cs_d      = 1'b0;
          addr_d    = '0;
          drain_d   = '0;
          lfsr_load = 1'b1;
        end else begin
          addr_d    = addr_q + ADDRWIDTH'(1);
          lfsr_step = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + DRW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      drain_q <= '0;
      pv_q    <= '0;
      pe_q    <= '0;
      pa_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      drain_q <= drain_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      pa_q    <= pa_d;
    end
  end

  assign addr      = addr_q;
  assign data      = data_q;
  assign cs        = cs_q;
  assign we        = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;
  assign state_dbg = state_q;

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 4, RAM address width.
REQ-002 SHALL have parameter DATAWIDTH, default 8, RAM data width.
REQ-003 SHALL have parameter SIZE, default 16, number of words tested (1..2**ADDRWIDTH).
REQ-004 SHALL have parameter SEED, default 8'hA5, non-zero LFSR start value.
REQ-005 SHALL have parameter TAPS, default 8'hB8, Galois LFSR feedback mask.
REQ-006 SHALL have parameter READ_LATENCY, default 1, cycles from read command edge to valid dataOut.
REQ-007 SHALL have port clk, input, 1, single clock, all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, begin test when sampled high in IDLE or DONE.
REQ-010 SHALL have ports addr, data, cs and we, outputs, widths ADDRWIDTH, DATAWIDTH, 1 and 1, registered RAM command bus.
REQ-011 SHALL have port dataOut, input, DATAWIDTH, RAM read data.
REQ-012 SHALL have port busy, output, 1, high from first command cycle until DONE.
REQ-013 SHALL have port done, output, 1, level-high in DONE.
REQ-014 SHALL have port pass, output, 1, high in DONE only when err_cnt==0.
REQ-015 SHALL have port err_cnt, output, ADDRWIDTH+1, mismatch count, saturating at all-ones.
REQ-016 SHALL have port fail_addr, output, ADDRWIDTH, address of first mismatch.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ, DRAIN and DONE.
REQ-018 SHALL transition IDLE/DONE->WRITE on start; clear err_cnt, fail_addr, pass and done; load LFSR with SEED; set addr=0.
REQ-019 SHALL, in WRITE, drive cs=1, we=1 and data=LFSR for SIZE consecutive cycles, with addr 0..SIZE-1 and LFSR stepped each cycle.
REQ-020 SHALL step the LFSR as next = (v>>1) ^ (v[0] ? TAPS : 0), so the sequence runs A5, EA, 75, ...
REQ-021 SHALL go WRITE->READ after address SIZE-1, reload the LFSR with SEED, drive cs=1 and we=0 for SIZE cycles with addr 0..SIZE-1, and hold data at 0.
REQ-022 SHALL carry expected data and address through a READ_LATENCY-deep valid pipeline and compare them with dataOut when that pipeline's output is valid.
REQ-023 SHALL go READ->DRAIN with cs=0 for READ_LATENCY cycles to finish outstanding compares, then DRAIN->DONE.
REQ-024 SHALL, on mismatch, increment err_cnt (saturating) and capture fail_addr on the first mismatch only.
REQ-025 SHALL keep busy high for exactly 2*SIZE+READ_LATENCY cycles.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL drive cs=0, we=0, addr=0 and data=0 in IDLE and DONE.
REQ-028 SHALL, when SIZE < 2**ADDRWIDTH, never issue addresses >= SIZE.

Reset
REQ-029 SHALL, on rst, asynchronously force state IDLE with addr, data, cs, we, busy, done, pass, err_cnt and fail_addr all at 0, and LFSR=SEED.
REQ-030 SHALL, on rst mid-test, abandon the test with no further RAM commands and stay in IDLE until a new start.

Structure
REQ-031 SHALL take its state encoding and default SEED/TAPS constants from package ram_bist_pkg.
REQ-032 SHALL place the LFSR (load, step, value) in sub-module ram_bist_lfsr, instantiated once and shared by the write and read phases.

Verification
REQ-033 SHALL verify default parameters against a fault-free single_port_ram: start -> 16 writes A5, EA, 75, ... to addr 0..15, then 16 reads; after 33 busy cycles done=1, pass=1, err_cnt=0.
REQ-034 SHALL verify a single fault, data bit 0 stuck-at-1 at addr 5 -> pass=0, err_cnt=1 (or 0 if the expected bit is already 1), fail_addr=5.
REQ-035 SHALL verify two faults at addr 3 and 9 corrupting all bits -> err_cnt=2, fail_addr=3.
REQ-036 SHALL verify rst asserted at write cycle 7 -> all outputs 0 immediately, cs stays 0; a later start gives a full pass run.
REQ-037 SHALL verify start pulsed during READ is ignored (busy count stays 33), and start in DONE clears results and reruns.
REQ-038 SHALL verify READ_LATENCY=2 with a 2-cycle RAM model -> pass=1 and busy for 34 cycles.
